rx_sample_sweep_scheduler: RTL and testbench

Sequences the receive sample circular buffer, a simple dual-port BRAM with 1-cycle registered read.
- On each accepted new sample it writes the sample into the buffer.
- It then sweeps the whole window from oldest to newest, streaming samples to the downstream correlator with first/last framing.
- It buffers one sample that arrives during a sweep and flags overrun when samples are lost.
- It sits between the ADC sample front-end and the correlator MAC, and owns all BRAM address generation.

---
 rtl/rx_sample_sweep_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_rx_sample_sweep_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_sweep_scheduler.sv
// rx_sample_sweep_scheduler
// Owns the address generation for the receive-sample circular buffer (a simple
// dual-port BRAM with a 1-cycle registered read). Each accepted sample is
// written once. The whole window is then streamed oldest-to-newest to the
// correlator with first/last framing. One sample arriving mid-sweep is held in
// a pending slot. Further arrivals are dropped and flagged by sticky overrun.
// Optional build macro: RX_SWEEP_ZERO_FILL_EN. When defined, never-written
// window locations stream as zero until the window has been filled once.
`timescale 1ns/1ps

module rx_sample_sweep_scheduler #(
    parameter int MEMORY_LENGTH = 510,
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 16
) (
    input  logic                     crx_clk,
    input  logic                     rrx_rst,
    input  logic                     erx_en,
    input  logic                     new_sample_trig,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     overrun_clr,
    output logic                     ram_wr_en,
    output logic [ADDR_W-1:0]        ram_wr_addr,
    output logic signed [DATA_W-1:0] ram_wr_data,
    output logic [ADDR_W-1:0]        ram_rd_addr,
    input  logic signed [DATA_W-1:0] ram_rd_data,
    output logic signed [DATA_W-1:0] sweep_data,
    output logic                     sweep_valid,
    output logic                     sweep_first,
    output logic                     sweep_last,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEMORY_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_SWEEP,
        S_DRAIN
    } state_t;

    state_t                     r_state;
    logic [ADDR_W-1:0]          r_wr_ptr;
    logic [ADDR_W-1:0]          r_rd_addr;
    logic [ADDR_W-1:0]          r_rd_cnt;
    logic                       r_pend_valid;
    logic signed [DATA_W-1:0]   r_pend_data;
    logic                       r_wr_en;
    logic [ADDR_W-1:0]          r_wr_addr;
    logic signed [DATA_W-1:0]   r_wr_data;
    logic                       r_sweep_valid;
    logic                       r_sweep_first;
    logic                       r_sweep_last;
    logic                       r_overrun;

    logic                       w_accept;
    logic                       w_drop;
    logic                       w_in_sweep;
    logic [ADDR_W-1:0]          w_wr_ptr_next;
    logic [ADDR_W-1:0]          w_rd_addr_next;

    assign w_accept       = new_sample_trig && erx_en;
    assign w_drop         = w_accept && (r_state != S_IDLE) && r_pend_valid;
    assign w_in_sweep     = (r_state == S_SWEEP);
    assign w_wr_ptr_next  = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_addr_next = (r_rd_addr == LAST_IDX) ? '0 : r_rd_addr + 1'b1;

`ifdef RX_SWEEP_ZERO_FILL_EN
    localparam int                CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  ML_CNT = CNT_W'(MEMORY_LENGTH);

    logic [CNT_W-1:0]           r_fill_cnt;
    logic                       r_sweep_zero;
    logic                       w_zero_idx;

    // Sweep index k addresses a never-written slot while k < MEMORY_LENGTH - fill_cnt.
    assign w_zero_idx = (({1'b0, r_rd_cnt} + r_fill_cnt) < ML_CNT);

    // Fill count and zero-mask flag, the flag aligned with the BRAM read latency.
    always_ff @(posedge crx_clk or negedge rrx_rst) begin
        if (!rrx_rst) begin
            r_fill_cnt   <= '0;
            r_sweep_zero <= 1'b0;
        end else begin
            r_sweep_zero <= w_in_sweep && w_zero_idx;
            if ((r_state == S_WRITE) && (r_fill_cnt != ML_CNT)) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
        end
    end

    assign sweep_data = (r_sweep_valid && !r_sweep_zero) ? ram_rd_data : '0;
`else
    assign sweep_data = r_sweep_valid ? ram_rd_data : '0;
`endif

    // Main sequencer: state, pointers, pending slot, overrun and all registered outputs.
    always_ff @(posedge crx_clk or negedge rrx_rst) begin
        if (!rrx_rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_addr     <= '0;
            r_rd_cnt      <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_data   <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_sweep_valid <= 1'b0;
            r_sweep_first <= 1'b0;
            r_sweep_last  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_wr_en       <= 1'b0;
            r_sweep_valid <= w_in_sweep;
            r_sweep_first <= w_in_sweep && (r_rd_cnt == '0);
            r_sweep_last  <= w_in_sweep && (r_rd_cnt == LAST_IDX);

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end

            if ((r_state != S_IDLE) && w_accept && !r_pend_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= sample_in;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend_valid) begin
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_wr_ptr;
                        r_wr_data <= r_pend_data;
                        if (w_accept) begin
                            r_pend_data <= sample_in;
                        end else begin
                            r_pend_valid <= 1'b0;
                        end
                    end else if (w_accept) begin
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_wr_ptr;
                        r_wr_data <= sample_in;
                    end
                end
                S_WRITE: begin
                    r_wr_ptr  <= w_wr_ptr_next;
                    r_rd_addr <= w_wr_ptr_next;
                    r_rd_cnt  <= '0;
                    r_state   <= S_SWEEP;
                end
                S_SWEEP: begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    if (r_rd_cnt == LAST_IDX) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_rd_addr <= w_rd_addr_next;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_wr_en   = r_wr_en;
    assign ram_wr_addr = r_wr_addr;
    assign ram_wr_data = r_wr_data;
    assign ram_rd_addr = r_rd_addr;
    assign sweep_valid = r_sweep_valid;
    assign sweep_first = r_sweep_first;
    assign sweep_last  = r_sweep_last;
    assign busy        = (r_state != S_IDLE) || r_pend_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_rx_sample_sweep_scheduler.sv
// Testbench for rx_sample_sweep_scheduler.
// A behavioural BRAM sits on the DUT memory ports. A reference model of the
// circular window predicts every sweep and pushes the expected stream into a
// scoreboard queue, which a negedge monitor pops whenever sweep_valid is high.
// A short window keeps the wrap-around scenario within a small cycle count.
`timescale 1ns/1ps

module tb_rx_sample_sweep_scheduler;

    localparam int ML     = 12;
    localparam int AW     = 4;
    localparam int DW     = 16;
    localparam int BOUND  = 3 * ML + 20;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic                  en;
    logic                  trig;
    logic signed [DW-1:0]  sampleIn;
    logic                  ovrClr;
    logic                  ramWrEn;
    logic [AW-1:0]         ramWrAddr;
    logic signed [DW-1:0]  ramWrData;
    logic [AW-1:0]         ramRdAddr;
    logic signed [DW-1:0]  ramRdData;
    logic signed [DW-1:0]  sweepData;
    logic                  sweepValid;
    logic                  sweepFirst;
    logic                  sweepLast;
    logic                  busy;
    logic                  overrun;

    int checks = 0;
    int errors = 0;
    int validCount = 0;

    logic [DW-1:0]   bram   [2**AW];
    logic [DW-1:0]   refMem [ML];
    int              refPtr;
    int              refFill;
    logic [DW+1:0]   expQ [$];

    rx_sample_sweep_scheduler #(
        .MEMORY_LENGTH(ML),
        .ADDR_W       (AW),
        .DATA_W       (DW)
    ) dut (
        .crx_clk        (clk),
        .rrx_rst        (rstN),
        .erx_en         (en),
        .new_sample_trig(trig),
        .sample_in      (sampleIn),
        .overrun_clr    (ovrClr),
        .ram_wr_en      (ramWrEn),
        .ram_wr_addr    (ramWrAddr),
        .ram_wr_data    (ramWrData),
        .ram_rd_addr    (ramRdAddr),
        .ram_rd_data    (ramRdData),
        .sweep_data     (sweepData),
        .sweep_valid    (sweepValid),
        .sweep_first    (sweepFirst),
        .sweep_last     (sweepLast),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Behavioural simple dual-port BRAM with registered read
    always @(posedge clk) begin
        if (ramWrEn) bram[ramWrAddr] <= ramWrData;
        ramRdData <= bram[ramRdAddr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every streamed sample must match the next scoreboard entry
    always @(negedge clk) begin
        logic [DW+1:0] exp;
        if (rstN && sweepValid) begin
            validCount++;
            exp = (expQ.size() != 0) ? expQ.pop_front() : 'x;
            checkOutput("sweep {first,last,data}", 32'({sweepFirst, sweepLast, sweepData}), 32'(exp));
        end
    end

    // Reference window: record an accepted write and optionally predict its sweep
    task automatic modelWrite(input logic [DW-1:0] s, input bit push);
        logic [DW-1:0] d;
        refMem[refPtr] = s;
        refPtr = (refPtr == ML - 1) ? 0 : refPtr + 1;
        if (refFill < ML) refFill++;
        if (push) begin
            for (int k = 0; k < ML; k++) begin
                d = refMem[(refPtr + k) % ML];
`ifdef RX_SWEEP_ZERO_FILL_EN
                if (k < ML - refFill) d = '0;
`endif
                expQ.push_back({(k == 0), (k == ML - 1), d});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic t, input logic [DW-1:0] s, input logic clr);
        trig     = t;
        sampleIn = s;
        ovrClr   = clr;
        tick();
        trig     = 1'b0;
        ovrClr   = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < BOUND) begin
            tick();
            n++;
        end
        checkOutput("waitIdle busy within bound", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        int vStart;
        rstN = 1'b0; en = 1'b1; trig = 1'b0; sampleIn = '0; ovrClr = 1'b0;
        refPtr = 0; refFill = 0;
        for (int i = 0; i < 2**AW; i++) bram[i] = 16'hC000 + 16'(i);
        for (int i = 0; i < ML; i++) refMem[i] = 16'hC000 + 16'(i);

        // Reset state
        repeat (2) tick();
        checkOutput("reset ram_wr_en", 32'(ramWrEn), 0);
        checkOutput("reset ram_wr_addr", 32'(ramWrAddr), 0);
        checkOutput("reset ram_wr_data", 32'(ramWrData), 0);
        checkOutput("reset ram_rd_addr", 32'(ramRdAddr), 0);
        checkOutput("reset sweep_valid", 32'(sweepValid), 0);
        checkOutput("reset sweep_first/last", 32'({sweepFirst, sweepLast}), 0);
        checkOutput("reset sweep_data", 32'(sweepData), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset overrun", 32'(overrun), 0);
        rstN = 1'b1;
        tick();

        // Single trigger: write timing, sweep latency, framing
        modelWrite(16'h1234, 1'b1);
        applyStimulus(1'b1, 16'h1234, 1'b0);
        checkOutput("T+1 ram_wr_en", 32'(ramWrEn), 1);
        checkOutput("T+1 ram_wr_addr", 32'(ramWrAddr), 0);
        checkOutput("T+1 ram_wr_data", 32'(ramWrData), 32'h1234);
        checkOutput("T+1 busy", 32'(busy), 1);
        tick();
        checkOutput("T+2 first rd_addr", 32'(ramRdAddr), 1);
        checkOutput("T+2 ram_wr_en low", 32'(ramWrEn), 0);
        tick();
        checkOutput("T+3 valid/first", 32'({sweepValid, sweepFirst}), 32'b11);
        repeat (ML - 1) tick();
        checkOutput("T+2+ML valid/last", 32'({sweepValid, sweepLast}), 32'b11);
        tick();
        checkOutput("T+3+ML idle busy", 32'(busy), 0);
        checkOutput("T+3+ML valid low", 32'(sweepValid), 0);

        // ML+2 sequential triggers: window wraps, final sweep holds 3..ML+2
        for (int i = 1; i <= ML + 2; i++) begin
            modelWrite(16'(i), 1'b1);
            applyStimulus(1'b1, 16'(i), 1'b0);
            waitIdle();
        end

        // One trigger during SWEEP: pended, written right after IDLE
        modelWrite(16'h0A0A, 1'b1);
        applyStimulus(1'b1, 16'h0A0A, 1'b0);
        repeat (2) tick();
        modelWrite(16'h0B0B, 1'b1);
        applyStimulus(1'b1, 16'h0B0B, 1'b0);
        checkOutput("pend busy", 32'(busy), 1);
        checkOutput("pend no overrun", 32'(overrun), 0);
        repeat (ML - 1) tick();
        checkOutput("pend idle cycle wr_en", 32'(ramWrEn), 0);
        checkOutput("pend idle cycle busy", 32'(busy), 1);
        tick();
        checkOutput("pend second write en", 32'(ramWrEn), 1);
        checkOutput("pend second write data", 32'(ramWrData), 32'h0B0B);
        waitIdle();

        // Two extra triggers in one sweep: overrun, clear priority
        modelWrite(16'h0C0C, 1'b1);
        applyStimulus(1'b1, 16'h0C0C, 1'b0);
        modelWrite(16'h0D0D, 1'b1);
        applyStimulus(1'b1, 16'h0D0D, 1'b0);
        checkOutput("first pend no overrun", 32'(overrun), 0);
        applyStimulus(1'b1, 16'h0E0E, 1'b0);
        checkOutput("drop sets overrun", 32'(overrun), 1);
        applyStimulus(1'b1, 16'h0F0F, 1'b1);
        checkOutput("drop beats clr", 32'(overrun), 1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("clr alone", 32'(overrun), 0);
        waitIdle();

        // Disabled triggers are ignored
        en = 1'b0;
        applyStimulus(1'b1, 16'h5555, 1'b0);
        checkOutput("disabled wr_en", 32'(ramWrEn), 0);
        checkOutput("disabled busy", 32'(busy), 0);
        tick();
        checkOutput("disabled busy later", 32'(busy), 0);

        // Enable dropped mid-sweep: sweep still completes in full
        en = 1'b1;
        vStart = validCount;
        modelWrite(16'h6666, 1'b1);
        applyStimulus(1'b1, 16'h6666, 1'b0);
        repeat (3) tick();
        en = 1'b0;
        applyStimulus(1'b1, 16'h7777, 1'b0);
        waitIdle();
        checkOutput("en drop valid count", 32'(validCount - vStart), 32'(ML));
        checkOutput("en drop no overrun", 32'(overrun), 0);

        // Async reset mid-sweep, then restart at address 0
        en = 1'b1;
        modelWrite(16'h8888, 1'b1);
        applyStimulus(1'b1, 16'h8888, 1'b0);
        repeat (3) tick();
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async rst sweep_valid", 32'(sweepValid), 0);
        checkOutput("async rst busy", 32'(busy), 0);
        checkOutput("async rst wr_en", 32'(ramWrEn), 0);
        repeat (2) tick();
        rstN = 1'b1;
        expQ.delete();
        refPtr = 0;
        refFill = 0;
        tick();
        modelWrite(16'h9999, 1'b1);
        applyStimulus(1'b1, 16'h9999, 1'b0);
        checkOutput("post-reset wr_en", 32'(ramWrEn), 1);
        checkOutput("post-reset wr_addr", 32'(ramWrAddr), 0);
        waitIdle();

        checkOutput("scoreboard drained", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
